// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: serial transmit stage between the TX FIFO and the TX pin.
// Pops one word per frame through the FIFO read-enable / registered-data port
// and sends it as: start bit, WORD_LEN data bits LSB first, optional parity,
// then STOP_BITS stop bits. Each bit lasts CLKS_PER_BIT = CLK_FREQ/BAUD clocks.
//
// Ports:
//   clk         system clock, all state on the rising edge
//   rst         asynchronous active-low reset
//   en          start gate; a frame already in progress always completes
//   fifo_empty  FIFO empty flag, looked at only while idle
//   fifo_data   FIFO registered read data, valid the cycle after fifo_re
//   fifo_re     FIFO read enable, one-cycle pulse per word
//   tx          serial line, idle high
//   busy        high whenever the transmitter is not idle
//   done        one-cycle pulse on the last clock of the final stop bit
module fifo_uart_tx #(
    parameter int unsigned CLK_FREQ  = 50000000,
    parameter int unsigned BAUD      = 115200,
    parameter int unsigned WORD_LEN  = 8,
    parameter int unsigned PARITY    = 0,
    parameter int unsigned STOP_BITS = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                fifo_empty,
    input  logic [WORD_LEN-1:0] fifo_data,
    output logic                fifo_re,
    output logic                tx,
    output logic                busy,
    output logic                done
);

    localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int unsigned CNT_W        = $clog2(CLKS_PER_BIT);
    localparam int unsigned BIT_W        = $clog2(WORD_LEN) + 1;

    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] DATA_LAST  = BIT_W'(WORD_LEN - 1);
    localparam logic [BIT_W-1:0] STOP_LAST  = BIT_W'(STOP_BITS - 1);
    localparam logic             HAS_PARITY = (PARITY != 0);
    localparam logic             ODD_PARITY = (PARITY == 2);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_LOAD,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [BIT_W-1:0]    bit_q, bit_d;
    logic [WORD_LEN-1:0] shift_q, shift_d;
    logic                par_q, par_d;
    logic                armed_q, armed_d;
    logic                tx_q, tx_d;
    logic                re_q, re_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                bit_end;

    // Last clock of the current bit period.
    assign bit_end = (cnt_q == CNT_LAST);

    // Next-state logic; outputs are computed from the next state so that
    // they are registered and line up with the state they belong to.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        par_d   = par_q;
        // armed_q holds off the first fetch by one edge after reset release.
        armed_d = 1'b1;

        case (state_q)
            ST_IDLE: begin
                if (armed_q && en && !fifo_empty) begin
                    state_d = ST_FETCH;
                end
            end

            ST_FETCH: begin
                state_d = ST_LOAD;
            end

            ST_LOAD: begin
                // Parity is taken from the captured word before shifting starts.
                shift_d = fifo_data;
                par_d   = (^fifo_data) ^ ODD_PARITY;
                cnt_d   = '0;
                bit_d   = '0;
                state_d = ST_START;
            end

            ST_START: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    state_d = ST_DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            ST_DATA: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    shift_d = shift_q >> 1;
                    if (bit_q == DATA_LAST) begin
                        bit_d   = '0;
                        state_d = HAS_PARITY ? ST_PARITY : ST_STOP;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            ST_PARITY: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    state_d = ST_STOP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            ST_STOP: begin
                // bit_q counts stop bits here.
                if (bit_end) begin
                    cnt_d = '0;
                    if (bit_q == STOP_LAST) begin
                        bit_d   = '0;
                        state_d = ST_IDLE;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
                bit_d   = '0;
            end
        endcase

        re_d   = (state_d == ST_FETCH);
        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_STOP) && (bit_d == STOP_LAST) && (cnt_d == CNT_LAST);

        case (state_d)
            ST_START:  tx_d = 1'b0;
            ST_DATA:   tx_d = shift_d[0];
            ST_PARITY: tx_d = par_d;
            default:   tx_d = 1'b1;
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            armed_q <= 1'b0;
            tx_q    <= 1'b1;
            re_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            armed_q <= armed_d;
            tx_q    <= tx_d;
            re_q    <= re_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign fifo_re = re_q;
    assign tx      = tx_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule
